seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexing controller for the 3-digit BCD 7-segment display path (ones, tens, hundreds).
- Drives the 4:1 digit mux select and the active-low anode enables. Digit slot 3 is never scanned.
- Buffers incoming digit values and commits them only at frame boundaries, so a frame never mixes old and new digits.
- Inserts a dead-time with all anodes off around every digit switch to suppress ghosting, and optionally blanks leading zeros.

Parameters:
DIV, 100000, clock cycles each digit is lit (dwell); must be >= 2
GUARD, 4, clock cycles with all anodes off between digits; must be >= 1
CW, 17, prescaler counter width; must satisfy 2^CW >= DIV

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; 0 = display off
upd  input  1  single-cycle strobe that loads d0/d1/d2
d0  input  4  ones digit (BCD)
d1  input  4  tens digit (BCD)
d2  input  4  hundreds digit (BCD)
blank_lz  input  1  1 = blank leading zeros
sel  output  2  digit select to the mux (00 ones, 01 tens, 10 hundreds; 11 never driven)
an  output  4  anode enables, active-low, one-hot-low when lit
q0  output  4  committed ones digit, feeds mux in_0
q1  output  4  committed tens digit, feeds mux in_1
q2  output  4  committed hundreds digit, feeds mux in_2
frame_done  output  1  1-cycle pulse on each 2->0 wrap

Behaviour:
- Reset (rst_n=0, asynchronous) sets: state=IDLE, sel=00, an=4'b1111, q0=q1=q2=0, pending regs=0, pend=0, frame_done=0, prescaler=0, guard counter=0.
- All outputs are registered.
- an[3] is 1 in every state.
- States are IDLE, SHOW and GUARD.
- IDLE:
  - an=1111, sel=00, prescaler=0.
  - upd in IDLE writes d0..d2 straight into q0..q2 on the next edge; pend stays 0.
  - en=1 moves to SHOW. The first cycle after en is sampled high shows an=1110, sel=00.
- SHOW:
  - The prescaler counts 0..DIV-1.
  - The anode for idx=sel is driven low unless that digit is blanked.
  - When prescaler==DIV-1: prescaler is cleared, the state moves to GUARD, and idx advances (2 wraps to 0, otherwise +1).
  - sel takes the new idx on GUARD entry, while anodes are off. an=1111 from the first GUARD cycle.
  - Each digit is lit for exactly DIV cycles.
- GUARD:
  - an=1111 for exactly GUARD cycles, then the state returns to SHOW with the new digit lit.
  - Frame period = 3*(DIV+GUARD) cycles.
- Update buffering:
  - upd while not IDLE captures d0..d2 into the pending regs and sets pend=1.
  - A later upd before commit overwrites the pending regs; the last value wins.
- Commit happens on the SHOW->GUARD transition with wrap (idx 2->0):
  - frame_done=1 for exactly that one cycle.
  - If pend=1, q0..q2 take the pending values and pend clears.
  - If upd coincides with the commit edge, the previously pending values commit and the new upd values become pending (pend stays 1).
- Leading-zero blanking (blank_lz=1), evaluated on the committed q values:
  - hundreds is blanked when q2==0;
  - tens is blanked when q2==0 and q1==0;
  - ones is never blanked.
  - A blanked digit keeps its full SHOW dwell with its anode high, so timing is unchanged.
- Non-BCD values (>9) pass through unmodified; there is no blanking or clamping of them.
- en=0 in SHOW or GUARD (mid-operation):
  - The next edge goes to IDLE: an=1111, sel=00, idx=0, prescaler and guard counter cleared, no frame_done.
  - Pending regs and pend are retained and commit at the next wrap. Any upd seen in IDLE overrides them with an immediate commit and clears pend.
- Reset asserted mid-frame forces the reset values immediately, independent of clk.

Test Plan:
1. DIV=8, GUARD=2. Reset, then load d=3,2,1 with upd while en=0, then en=1. Required: q=1,2,3 (q2..q0) next edge; an sequence 1110 (8 cycles), 1111 (2 cycles), 1101 (8), 1111 (2), 1011 (8), 1111 (2), repeating; sel changes only during an=1111; frame_done pulses every 30 cycles.
2. While scanning with q=1,2,3, pulse upd with d=9,8,7 mid-tens. Required: q unchanged until the 2->0 wrap; q0=9, q1=8, q2=7 on the frame_done cycle; pend cleared.
3. blank_lz=1, q2=0, q1=0, q0=5. Required: an=1111 throughout the tens and hundreds slots and 1110 in the ones slot; frame period still 30 cycles. Then q1=4: tens lights (an=1101) and hundreds stays dark.
4. upd with d=6,6,6 asserted exactly on the wrap edge while pending=1,1,1 exists. Required: q becomes 1,1,1 that edge, pend=1, and q becomes 6,6,6 at the following wrap.
5. Drop en during the hundreds SHOW slot. Required: next cycle an=1111, sel=00, no frame_done. Raise en again: an=1110 for a full 8 cycles.
6. Assert rst_n=0 asynchronously between clock edges during GUARD. Required: an=1111, sel=00, q=0, frame_done=0 immediately; state IDLE after release.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 3-digit 7-segment scan controller with frame-aligned digit commit,
// inter-digit dead-time and optional leading-zero blanking.
module seg_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int GUARD = 4,
  parameter int CW    = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       upd,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic       blank_lz,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic       frame_done
);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GUARD} state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_pre, w_pre;
  logic [GW-1:0]   r_gcnt, w_gcnt;
  logic [3:0]      r_p0, r_p1, r_p2;
  logic            r_pend;
  logic [1:0]      w_idx;
  logic            w_lit, w_fd, w_blk;
  logic [3:0]      w_an;

  always_comb begin
    w_state = r_state;
    w_idx   = sel;
    w_pre   = '0;
    w_gcnt  = '0;
    w_lit   = 1'b0;
    w_fd    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idx = 2'd0;
        if (en) begin
          w_state = S_SHOW;
          w_lit   = 1'b1;
        end
      end
      S_SHOW: begin
        if (!en) begin
          w_state = S_IDLE;
          w_idx   = 2'd0;
        end else if (r_pre == CW'(DIV - 1)) begin
          w_state = S_GUARD;
          w_idx   = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
          w_fd    = (sel == 2'd2);
        end else begin
          w_pre = r_pre + 1'b1;
          w_lit = 1'b1;
        end
      end
      S_GUARD: begin
        if (!en) begin
          w_state = S_IDLE;
          w_idx   = 2'd0;
        end else if (r_gcnt == GW'(GUARD - 1)) begin
          w_state = S_SHOW;
          w_lit   = 1'b1;
        end else begin
          w_gcnt = r_gcnt + 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_idx   = 2'd0;
      end
    endcase
  end

  // blanking looks at committed digits; they never change while a digit is being shown
  assign w_blk = blank_lz && (q2 == 4'd0) && ((w_idx == 2'd2) || ((w_idx == 2'd1) && (q1 == 4'd0)));
  assign w_an  = (w_lit && !w_blk) ? ~(4'b0001 << w_idx) : 4'b1111;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      sel        <= 2'd0;
      an         <= 4'b1111;
      frame_done <= 1'b0;
      r_pre      <= '0;
      r_gcnt     <= '0;
      q0         <= 4'd0;
      q1         <= 4'd0;
      q2         <= 4'd0;
      r_p0       <= 4'd0;
      r_p1       <= 4'd0;
      r_p2       <= 4'd0;
      r_pend     <= 1'b0;
    end else begin
      r_state    <= w_state;
      sel        <= w_idx;
      an         <= w_an;
      frame_done <= w_fd;
      r_pre      <= w_pre;
      r_gcnt     <= w_gcnt;
      if (r_state == S_IDLE) begin
        if (upd) begin
          q0     <= d0;
          q1     <= d1;
          q2     <= d2;
          r_pend <= 1'b0;
        end
      end else begin
        if (w_fd && r_pend) begin
          q0 <= r_p0;
          q1 <= r_p1;
          q2 <= r_p2;
        end
        if (upd) begin
          r_p0 <= d0;
          r_p1 <= d1;
          r_p2 <= d2;
        end
        r_pend <= upd || (r_pend && !w_fd);
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: frame-arithmetic reference model with per-cycle compare,
// directed scenarios and a randomized phase.
module tb_seg_scan_ctrl;
  localparam int DIV = 8;
  localparam int GUARD = 2;
  localparam int SLOT = DIV + GUARD;
  localparam int FRAME = 3 * SLOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       upd = 1'b0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0;
  logic       blank_lz = 1'b0;
  logic [1:0] sel;
  logic [3:0] an, q0, q1, q2;
  logic       frame_done;

  seg_scan_ctrl #(.DIV(DIV), .GUARD(GUARD), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .upd(upd), .d0(d0), .d1(d1), .d2(d2),
    .blank_lz(blank_lz), .sel(sel), .an(an), .q0(q0), .q1(q1), .q2(q2), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  bit go = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: k counts cycles since scanning started; slot and phase follow from k
  bit         active = 1'b0;
  int         k = 0;
  logic [3:0] mq[3] = '{4'd0, 4'd0, 4'd0};
  logic [3:0] mp[3] = '{4'd0, 4'd0, 4'd0};
  bit         mpend = 1'b0;
  bit         mblz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 0; k = 0; mpend = 0; mblz = 0;
      mq = '{4'd0, 4'd0, 4'd0};
      mp = '{4'd0, 4'd0, 4'd0};
    end else begin
      mblz = blank_lz;
      if (!active) begin
        if (upd) begin
          mq = '{d0, d1, d2};
          mpend = 0;
        end
        if (en) begin
          active = 1;
          k = 0;
        end
      end else begin
        if (!en) active = 0;
        else begin
          k++;
          if (k % FRAME == FRAME - GUARD && mpend) begin
            mq = mp;
            mpend = 0;
          end
        end
        if (upd) begin
          mp = '{d0, d1, d2};
          mpend = 1;
        end
      end
    end
  end

  logic [1:0] prev_sel = 2'd0;
  always @(negedge clk) begin
    if (go) begin
      int o, s, es;
      logic [3:0] ea;
      bit ef;
      o = k % SLOT;
      s = (k / SLOT) % 3;
      es = !active ? 0 : (o < DIV ? s : (s + 1) % 3);
      ea = 4'hf;
      if (active && o < DIV && !(mblz && mq[2] == 0 && (s == 2 || (s == 1 && mq[1] == 0))))
        ea = ~(4'b0001 << s);
      ef = active && (k % FRAME == FRAME - GUARD);
      chk("an", an, ea);
      chk("sel", sel, es);
      chk("frame_done", frame_done, ef);
      chk("q0", q0, mq[0]);
      chk("q1", q1, mq[1]);
      chk("q2", q2, mq[2]);
      if (sel != prev_sel) chk("sel_change_dark", an, 4'hf);
      prev_sel = sel;
    end
  end

  task automatic wait_k(input int m);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(active && k % FRAME == m) && n < 200);
    if (n >= 200) chk("wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_upd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    d0 = a; d1 = b; d2 = c; upd = 1;
    @(negedge clk);
    upd = 0;
  endtask

  initial begin
    int off = 0;
    int cnt;
    time t0;
    repeat (2) @(negedge clk);
    go = 1;
    chk("rst_an", an, 4'hf);
    chk("rst_sel", sel, 2'd0);
    chk("rst_q", {q2, q1, q0}, 12'h000);
    chk("rst_fd", frame_done, 1'b0);
    rst_n = 1;
    @(negedge clk);
    // load while idle commits directly
    pulse_upd(4'd3, 4'd2, 4'd1);
    chk("t1_q", {q2, q1, q0}, 12'h123);
    en = 1;
    @(negedge clk);
    chk("t1_first_an", an, 4'he);
    wait_k(28);
    chk("t1_fd", frame_done, 1'b1);
    t0 = $time;
    wait_k(28);
    chk("t1_period", ($time - t0) / 10, FRAME);
    // mid-frame update held until wrap
    wait_k(14);
    pulse_upd(4'd9, 4'd8, 4'd7);
    chk("t2_hold", {q2, q1, q0}, 12'h123);
    wait_k(28);
    chk("t2_commit", {q2, q1, q0}, 12'h789);
    // leading-zero blanking
    blank_lz = 1;
    pulse_upd(4'd5, 4'd0, 4'd0);
    wait_k(28);
    wait_k(13);
    chk("t3_tens_dark", an, 4'hf);
    wait_k(23);
    chk("t3_hund_dark", an, 4'hf);
    wait_k(3);
    chk("t3_ones_lit", an, 4'he);
    pulse_upd(4'd5, 4'd4, 4'd0);
    wait_k(28);
    wait_k(13);
    chk("t3_tens_lit", an, 4'hd);
    wait_k(23);
    chk("t3_hund_dark2", an, 4'hf);
    // update coinciding with the commit edge
    wait_k(5);
    pulse_upd(4'd1, 4'd1, 4'd1);
    wait_k(27);
    pulse_upd(4'd6, 4'd6, 4'd6);
    chk("t4_first", {q2, q1, q0}, 12'h111);
    wait_k(28);
    chk("t4_second", {q2, q1, q0}, 12'h666);
    // enable drop during hundreds
    wait_k(23);
    en = 0;
    @(negedge clk);
    chk("t5_an", an, 4'hf);
    chk("t5_sel", sel, 2'd0);
    chk("t5_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    en = 1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (an == 4'he) cnt++;
    end
    chk("t5_ones_dwell", cnt, 8);
    // randomized phase including non-BCD digits
    repeat (3000) begin
      upd = ($urandom_range(0, 15) == 0);
      d0 = 4'($urandom_range(0, 15));
      d1 = 4'($urandom_range(0, 15));
      d2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
      if (off == 0 && $urandom_range(0, 399) == 0) off = $urandom_range(1, 5);
      en = (off == 0);
      if (off > 0) off--;
      @(negedge clk);
    end
    upd = 0;
    en = 1;
    blank_lz = 0;
    // asynchronous reset during a guard interval
    wait_k(8);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_an", an, 4'hf);
    chk("t6_sel", sel, 2'd0);
    chk("t6_q", {q2, q1, q0}, 12'h000);
    chk("t6_fd", frame_done, 1'b0);
    en = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_idle_an", an, 4'hf);
    end
    en = 1;
    @(negedge clk);
    chk("t6_restart_an", an, 4'he);
    chk("t6_restart_sel", sel, 2'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
